// File: rtl/riscv_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// riscv_arb_pkg
// Shared types for the instruction/data memory arbiter.
//   arb_state_e : arbiter FSM state (IDLE, WAIT)
//   arb_owner_e : which requester owns the access in flight (OWN_IF, OWN_LS)
//   ARB_LAT_W   : width of the memory latency counter
// -----------------------------------------------------------------------------
package riscv_arb_pkg;

   localparam int ARB_LAT_W = 3;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } arb_state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_LS = 1'b1
   } arb_owner_e;

endpackage

// File: rtl/riscv_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// riscv_mem_arbiter_if
// Bundle of the fetch port, the load/store port and the memory command port.
//   master : arbiter view (drives grants, responses, memory command, busy)
//   slave  : environment view (drives requests and memory read data)
// Handshake: a requester raises req with its command and holds both stable
// until it sees gnt high in the same cycle; the matching rvalid arrives
// MEM_LAT cycles after that grant cycle and is never back-pressured.
// -----------------------------------------------------------------------------
interface riscv_mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);

   logic                  if_req;
   logic [ADDR_W-1:0]     if_addr;
   logic                  if_gnt;
   logic                  if_rvalid;
   logic [DATA_W-1:0]     if_rdata;

   logic                  ls_req;
   logic                  ls_we;
   logic [DATA_W/8-1:0]   ls_be;
   logic [ADDR_W-1:0]     ls_addr;
   logic [DATA_W-1:0]     ls_wdata;
   logic                  ls_gnt;
   logic                  ls_rvalid;
   logic [DATA_W-1:0]     ls_rdata;

   logic                  mem_en;
   logic                  mem_we;
   logic [DATA_W/8-1:0]   mem_be;
   logic [ADDR_W-1:0]     mem_addr;
   logic [DATA_W-1:0]     mem_wdata;
   logic [DATA_W-1:0]     mem_rdata;

   logic                  busy;

   modport master (
      input  if_req, if_addr,
      output if_gnt, if_rvalid, if_rdata,
      input  ls_req, ls_we, ls_be, ls_addr, ls_wdata,
      output ls_gnt, ls_rvalid, ls_rdata,
      output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
      input  mem_rdata,
      output busy
   );

   modport slave (
      output if_req, if_addr,
      input  if_gnt, if_rvalid, if_rdata,
      output ls_req, ls_we, ls_be, ls_addr, ls_wdata,
      input  ls_gnt, ls_rvalid, ls_rdata,
      input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
      output mem_rdata,
      input  busy
   );

endinterface

// File: rtl/riscv_mem_arbiter_select.sv
// -----------------------------------------------------------------------------
// riscv_arb_select
// Combinational winner selection between fetch and load/store.
//   if_req, ls_req : pending requests
//   starve_cnt     : consecutive load/store grants while fetch was waiting
//   window         : arbiter is able to issue a new access this cycle
//   sel_if, sel_ls : one-hot (or zero) winner
// -----------------------------------------------------------------------------
module riscv_arb_select #(
   parameter int STARVE_MAX = 4
) (
   input  logic       if_req,
   input  logic       ls_req,
   input  logic [3:0] starve_cnt,
   input  logic       window,
   output logic       sel_if,
   output logic       sel_ls
);

   logic starve_hit;

   // Load/store normally wins; once fetch has waited through STARVE_MAX
   // load/store grants it takes the next slot.
   assign starve_hit = if_req && (starve_cnt == 4'(STARVE_MAX));
   assign sel_ls     = window && ls_req && !starve_hit;
   assign sel_if     = window && if_req && !sel_ls;

endmodule

// File: rtl/riscv_mem_arbiter.sv
// -----------------------------------------------------------------------------
// riscv_mem_arbiter
// Shares one single-port synchronous memory between instruction fetch and
// load/store. Each access is held for MEM_LAT cycles; the response cycle is
// also a grant window so MEM_LAT=1 sustains one access per cycle.
// Ports:
//   clk         : rising-edge clock
//   rst         : synchronous active-low reset
//   bus         : riscv_mem_arbiter_if.master (fetch, load/store, memory, busy)
//   dbg_state   : current FSM state
//   if_wait_cnt : fetch cycles spent requesting without grant (perf build)
//   ls_wait_cnt : load/store cycles spent requesting without grant (perf build)
// Build option: RISCV_ARB_PERF_EN adds the two saturating wait counters.
// -----------------------------------------------------------------------------
module riscv_mem_arbiter
   import riscv_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   riscv_mem_arbiter_if.master   bus,
   output arb_state_e            dbg_state
`ifdef RISCV_ARB_PERF_EN
   ,
   output logic [31:0]           if_wait_cnt,
   output logic [31:0]           ls_wait_cnt
`endif
);

   arb_state_e             state, nxt_state;
   arb_owner_e             owner;
   logic                   owner_we;
   logic [ARB_LAT_W-1:0]   lat_cnt;
   logic [3:0]             starve_cnt;

   logic                   window, resp, grant;
   logic                   sel_if, sel_ls;
   logic [ADDR_W-1:0]      addr_sel;
   logic [DATA_W-1:0]      rdata_sel;

   // lat_cnt only reaches 1 in WAIT, but the state term keeps the intent clear.
   // Everything is gated with rst so outputs read zero during a reset cycle.
   assign resp   = rst && (state == WAIT) && (lat_cnt == ARB_LAT_W'(1));
   assign window = rst && ((state == IDLE) || resp);
   assign grant  = sel_if || sel_ls;

   riscv_arb_select #(
      .STARVE_MAX (STARVE_MAX)
   ) u_select (
      .if_req     (bus.if_req),
      .ls_req     (bus.ls_req),
      .starve_cnt (starve_cnt),
      .window     (window),
      .sel_if     (sel_if),
      .sel_ls     (sel_ls)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= nxt_state;
   end

   // Next-state logic
   always_comb begin
      nxt_state = state;
      case (state)
         IDLE: if (grant) nxt_state = WAIT;
         WAIT: begin
            if (grant)        nxt_state = WAIT;
            else if (resp)    nxt_state = IDLE;
         end
         default: nxt_state = IDLE;
      endcase
   end

   // Access bookkeeping: owner, store flag, latency and starvation counters
   always_ff @(posedge clk) begin
      if (!rst) begin
         owner      <= OWN_IF;
         owner_we   <= 1'b0;
         lat_cnt    <= '0;
         starve_cnt <= '0;
      end else begin
         if (grant) begin
            owner    <= sel_ls ? OWN_LS : OWN_IF;
            owner_we <= sel_ls && bus.ls_we;
            lat_cnt  <= ARB_LAT_W'(MEM_LAT);
         end else if (state == WAIT) begin
            lat_cnt  <= lat_cnt - ARB_LAT_W'(1);
         end

         if (!bus.if_req || sel_if)
            starve_cnt <= '0;
         else if (sel_ls && (starve_cnt != 4'(STARVE_MAX)))
            starve_cnt <= starve_cnt + 4'd1;
      end
   end

   // Output logic
   always_comb begin
      addr_sel      = '0;
      rdata_sel     = '0;
      bus.if_gnt    = sel_if;
      bus.ls_gnt    = sel_ls;
      bus.mem_en    = grant;
      bus.mem_we    = 1'b0;
      bus.mem_be    = '0;
      bus.mem_wdata = '0;
      bus.if_rvalid = 1'b0;
      bus.if_rdata  = '0;
      bus.ls_rvalid = 1'b0;
      bus.ls_rdata  = '0;
      bus.busy      = rst && (state == WAIT);

      if (sel_ls) begin
         addr_sel      = bus.ls_addr;
         bus.mem_we    = bus.ls_we;
         bus.mem_be    = bus.ls_be;
         bus.mem_wdata = bus.ls_wdata;
      end else if (sel_if) begin
         addr_sel      = bus.if_addr;
      end
      bus.mem_addr = addr_sel;

      if (resp) begin
         rdata_sel = bus.mem_rdata;
         if (owner == OWN_IF) begin
            bus.if_rvalid = 1'b1;
            bus.if_rdata  = rdata_sel;
         end else begin
            bus.ls_rvalid = 1'b1;
            bus.ls_rdata  = owner_we ? '0 : rdata_sel;
         end
      end
   end

   assign dbg_state = state;

`ifdef RISCV_ARB_PERF_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         if_wait_cnt <= '0;
         ls_wait_cnt <= '0;
      end else begin
         if (bus.if_req && !sel_if && (if_wait_cnt != 32'hFFFF_FFFF))
            if_wait_cnt <= if_wait_cnt + 32'd1;
         if (bus.ls_req && !sel_ls && (ls_wait_cnt != 32'hFFFF_FFFF))
            ls_wait_cnt <= ls_wait_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: doc/riscv_mem_arbiter.md
# riscv_mem_arbiter

Shares the single-port synchronous instruction/data memory between the core's instruction-fetch stage and its load/store stage. The block sequences each access over the fixed memory read latency and returns read data to the owning requester. Load/store requests have priority, and a starvation limit guarantees forward progress for fetch. It sits between `riscv_top`'s fetch and memory stages and the memory macro.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width (multiple of 8)
- `MEM_LAT`, 1, memory read latency in cycles (legal 1..4)
- `STARVE_MAX`, 4, consecutive load/store grants allowed while fetch waits (legal 1..15)

- `clk` in 1 — the single clock; all logic on its rising edge
- `rst` in 1 — synchronous, active-low reset
- `if_req` in 1 — fetch request; held with `if_addr` until `if_gnt`
- `if_addr` in ADDR_W — fetch address
- `if_gnt` out 1 — fetch accepted this cycle
- `if_rvalid` out 1 — fetch data valid
- `if_rdata` out DATA_W — fetch data; 0 when `if_rvalid`=0
- `ls_req` in 1 — load/store request; held stable until `ls_gnt`
- `ls_we` in 1 — 1 = store
- `ls_be` in DATA_W/8 — byte enables for stores
- `ls_addr` in ADDR_W — load/store address
- `ls_wdata` in DATA_W — store data
- `ls_gnt` out 1 — load/store accepted this cycle
- `ls_rvalid` out 1 — load data valid / store complete
- `ls_rdata` out DATA_W — load data; 0 for stores and when `ls_rvalid`=0
- `mem_en`, `mem_we` out 1 — memory strobe and write enable
- `mem_be` out DATA_W/8, `mem_addr` out ADDR_W, `mem_wdata` out DATA_W — memory command
- `mem_rdata` in DATA_W — memory read data, valid MEM_LAT cycles after the `mem_en` edge
- `busy` out 1 — an access is in flight

## Operation
- FSM states: IDLE and WAIT. Registers: owner (IF/LS), latency counter `lat_cnt` (3 bits), starvation counter `starve_cnt` (4 bits).
- Grant window: the FSM is in IDLE, or in WAIT with `lat_cnt`==1 (response cycle).
- In the grant window with any request present, select a winner:
  - LS wins if `ls_req`=1, unless `if_req`=1 and `starve_cnt`==STARVE_MAX.
  - Otherwise IF wins if `if_req`=1.
- On a grant, combinationally assert the winner's `gnt` and `mem_en`. Drive `mem_addr`/`mem_we`/`mem_be`/`mem_wdata` from the winner; IF grants force `mem_we`=0 and `mem_be`=0.
- At that edge: owner ← winner, `lat_cnt` ← MEM_LAT, state ← WAIT.
- In WAIT, decrement `lat_cnt` each cycle. When `lat_cnt`==1, the owner's `rvalid`=1 and its `rdata`=`mem_rdata` (stores: `rdata`=0).
  - With no new grant in that cycle, next state is IDLE.
- `starve_cnt` update:
  - +1 on each LS grant while `if_req`=1
  - cleared on an IF grant or any cycle with `if_req`=0
  - saturates at STARVE_MAX
- When not granting, all `mem_*` outputs are 0.
- `busy`=1 whenever the state is WAIT.

## Timing
- Reset (`rst`=0 at an edge): state IDLE, `lat_cnt`=0, `starve_cnt`=0. All outputs 0 (`gnt`, `rvalid`, `rdata`, `mem_*`, `busy`, perf counters).
- Reset mid-access drops the in-flight response: no `rvalid` is ever produced for it.
- Grant is same-cycle (0 latency from `req` in IDLE). Response arrives exactly MEM_LAT cycles after the grant cycle.
- Throughput is one access per MEM_LAT cycles. With MEM_LAT=1, back-to-back accesses run every cycle, with `rvalid` and the next `gnt` in the same cycle.
- Simultaneous `if_req` and `ls_req` resolve per the priority rule in one cycle. The loser's `gnt` stays 0, and it must keep its request stable.
- A request dropped before grant is legal and is simply not serviced.

## Configuration
- `RISCV_ARB_PERF_EN` defined:
  - adds output ports `if_wait_cnt` and `ls_wait_cnt` (32 bits each)
  - each counts cycles with `req`=1 and `gnt`=0, saturating at 0xFFFFFFFF, reset to 0
- Undefined: the ports and counters do not exist. Arbitration behaviour is identical either way.

## Structure
- Package `riscv_arb_pkg` holds:
  - `arb_state_e` {IDLE, WAIT}
  - `arb_owner_e` {OWN_IF, OWN_LS}
  - constant `ARB_LAT_W`=3
- One sub-module, `riscv_arb_select`: purely combinational winner selection from `if_req`, `ls_req`, `starve_cnt`, STARVE_MAX and grant-window. Outputs `sel_if`, `sel_ls`.

## Test plan
- Single fetch, MEM_LAT=1, `if_addr`=0x40, memory returns 0x00500093 → `if_gnt` in cycle 0, `mem_addr`=0x40 in cycle 0, `if_rvalid`=1 with `if_rdata`=0x00500093 in cycle 1, `busy` high in cycle 1 only.
- Store then load, MEM_LAT=2: store 0xDEADBEEF to 0x100 with `be`=0xF, then load 0x100 → `ls_rvalid` at cycles 2 and 4, `ls_rdata` 0 then 0xDEADBEEF, `mem_we` 1 then 0.
- Starvation, STARVE_MAX=4, both requests held high continuously → grant pattern LS,LS,LS,LS,IF repeating.
- Reset mid-access: grant a load with MEM_LAT=3, drop `rst` one cycle later for one cycle → no `ls_rvalid`, all outputs 0 in the cycle after reset, next request granted normally.
- Back-to-back with MEM_LAT=1: `ls_req` for addresses 0x0, 0x4, 0x8 on consecutive cycles → 3 grants in 3 cycles, rvalid in cycles 1–3 with matching data.
- With `RISCV_ARB_PERF_EN`: fetch blocked for 7 cycles behind loads → `if_wait_cnt`=7. Without the macro, the build has no such port.
